// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has fixed priority over a
// queued secondary requester, with a pending-register scoreboard and starvation freeze.
module rf_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              sec_valid,
    output logic              sec_ready,
    input  logic [REG_W-1:0]  sec_rd,
    input  logic [DATA_W-1:0] sec_data,
    input  logic              issue_valid,
    input  logic [REG_W-1:0]  issue_rd,
    input  logic [REG_W-1:0]  chk_rs1,
    input  logic [REG_W-1:0]  chk_rs2,
    input  logic [REG_W-1:0]  chk_rd,
    output logic              busy,
    output logic              stall_req,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              err
);

    localparam int NREG  = 1 << REG_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WC_W  = $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [WC_W-1:0]  WAIT_MAX  = WC_W'(MAX_WAIT);
    localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(MAX_WAIT - 1);

    // Secondary result queue
    logic [REG_W-1:0]  fifo_rd_q   [DEPTH];
    logic [REG_W-1:0]  fifo_rd_d   [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [NREG-1:0]   pending_q, pending_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              stall_req_q, stall_req_d;
    logic              err_q, err_d;

    logic              wb_write;
    logic              fifo_empty;
    logic              fifo_full;
    logic [REG_W-1:0]  head_rd;
    logic [DATA_W-1:0] head_data;
    logic              push;
    logic              head_commit;
    logic              denied;

    always_comb begin
        wb_write    = wb_valid && (wb_rd != '0);
        fifo_empty  = (count_q == '0);
        fifo_full   = (count_q == FULL_CNT);
        head_rd     = fifo_rd_q[rd_ptr_q];
        head_data   = fifo_data_q[rd_ptr_q];
        // Ready reflects registered occupancy only: a pop this cycle does not free a slot.
        sec_ready   = !rst && !fifo_full;
        push        = sec_valid && sec_ready && (sec_rd != '0);
        head_commit = !rst && !fifo_empty && !wb_write;
        denied      = !rst && !fifo_empty && wb_write;
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (!rst) begin
            if (wb_write) begin
                rf_we    = 1'b1;
                rf_waddr = wb_rd;
                rf_wdata = wb_data;
            end else if (!fifo_empty) begin
                rf_we    = 1'b1;
                rf_waddr = head_rd;
                rf_wdata = head_data;
            end
        end
    end

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_rd_d[wr_ptr_q]   = sec_rd;
            fifo_data_d[wr_ptr_q] = sec_data;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (head_commit) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, head_commit})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Clear before set so an issue to the committing register keeps it pending.
    always_comb begin
        pending_d = pending_q;
        if (head_commit) begin
            pending_d[head_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        busy = pending_q[chk_rs1] | pending_q[chk_rs2] | pending_q[chk_rd];
    end

    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        stall_req_d = stall_req_q;
        if (head_commit) begin
            wait_cnt_d  = '0;
            stall_req_d = 1'b0;
        end else if (denied) begin
            if (wait_cnt_q != WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q + WC_W'(1);
            end
            if (wait_cnt_q == WAIT_LAST) begin
                stall_req_d = 1'b1;
            end
        end
    end

    // Sticky: double issue to a pending register, or WB traffic during a freeze.
    always_comb begin
        err_d = err_q;
        if (issue_valid && (issue_rd != '0) && pending_q[issue_rd]) begin
            err_d = 1'b1;
        end
        if (stall_req_q && wb_valid) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pending_q   <= '0;
            wait_cnt_q  <= '0;
            stall_req_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_req_q <= stall_req_d;
            err_q       <= err_d;
        end
    end

    assign stall_req = stall_req_q;
    assign err       = err_q;

endmodule
